i4004_bus_master: RTL and testbench

I4004_BUS_MASTER -- requirements
Module: i4004_bus_master

---
 rtl/i4004_bus_master.sv | 174 +++++++++++++++++
 tb/tb_i4004_bus_master.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/i4004_bus_master.sv
// MCS-4 bus master: generates clk1/clk2/sync/bus_reset from a 64-tick instruction
// cycle and sequences one SRC or I/O command (or a NOP) on the shared data bus per cycle.
module i4004_bus_master #(
    parameter int RESET_CYCLES = 32
) (
    input  logic       sysclk,
    input  logic       reset_n,
    output logic       clk1,
    output logic       clk2,
    output logic       sync,
    output logic       bus_reset,
    output logic       cm,
    inout  tri   [3:0] data,
    input  logic       req_valid,
    output logic       req_ready,
    input  logic       req_io,
    input  logic [3:0] req_opa,
    input  logic [7:0] req_data,
    output logic       rsp_valid,
    output logic [3:0] rsp_data
);

    localparam logic [3:0] OPR_NOP    = 4'h0;
    localparam logic [3:0] OPR_SRC    = 4'h2;
    localparam logic [3:0] OPA_SRC    = 4'h1;
    localparam logic [3:0] OPR_IO     = 4'hE;
    localparam logic [5:0] CNT_LAST   = 6'd63;
    localparam logic [5:0] SAMPLE_CNT = 6'd54;
    localparam logic [5:0] RSP_CNT    = 6'd55;
    localparam int         RCW        = (RESET_CYCLES > 1) ? $clog2(RESET_CYCLES) : 1;
    localparam logic [RCW-1:0] RST_LAST = RCW'(RESET_CYCLES - 1);

    typedef enum logic [2:0] {
        SUB_A1, SUB_A2, SUB_A3, SUB_M1, SUB_M2, SUB_X1, SUB_X2, SUB_X3
    } sub_t;

    logic [5:0]     cnt_reg, cnt_next;
    logic [RCW-1:0] rst_cnt_reg, rst_cnt_next;
    logic           bus_reset_reg, bus_reset_next;
    logic           cmd_valid_reg, cmd_valid_next;
    logic           cmd_io_reg, cmd_io_next;
    logic [3:0]     cmd_opa_reg, cmd_opa_next;
    logic [7:0]     cmd_data_reg, cmd_data_next;
    logic [3:0]     rsp_data_reg, rsp_data_next;

    sub_t       sub;
    logic [2:0] tick;
    logic       cycle_end;
    logic       accept;
    logic       cmd_read;
    logic       bus_oe;
    logic       data_drive;
    logic [3:0] data_out;

    assign sub       = sub_t'(cnt_reg[5:3]);
    assign tick      = cnt_reg[2:0];
    assign cycle_end = (cnt_reg == CNT_LAST);
    assign req_ready = cycle_end && !bus_reset_reg;
    assign accept    = req_valid && req_ready;
    assign cmd_read  = cmd_valid_reg && cmd_io_reg && cmd_opa_reg[3];

    // Counter is held at 0 in reset, so these decodes are naturally low then.
    assign clk1      = (tick == 3'd1) || (tick == 3'd2);
    assign clk2      = (tick == 3'd5) || (tick == 3'd6);
    assign sync      = (sub == SUB_X3);
    assign bus_reset = bus_reset_reg;
    assign rsp_valid = cmd_read && (cnt_reg == RSP_CNT);
    assign rsp_data  = rsp_data_reg;

    always_ff @(posedge sysclk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_reg       <= '0;
            rst_cnt_reg   <= '0;
            bus_reset_reg <= 1'b1;
            cmd_valid_reg <= 1'b0;
            cmd_io_reg    <= 1'b0;
            cmd_opa_reg   <= '0;
            cmd_data_reg  <= '0;
            rsp_data_reg  <= '0;
        end else begin
            cnt_reg       <= cnt_next;
            rst_cnt_reg   <= rst_cnt_next;
            bus_reset_reg <= bus_reset_next;
            cmd_valid_reg <= cmd_valid_next;
            cmd_io_reg    <= cmd_io_next;
            cmd_opa_reg   <= cmd_opa_next;
            cmd_data_reg  <= cmd_data_next;
            rsp_data_reg  <= rsp_data_next;
        end
    end

    always_comb begin
        cnt_next       = cnt_reg + 6'd1;
        rst_cnt_next   = rst_cnt_reg;
        bus_reset_next = bus_reset_reg;
        cmd_valid_next = cmd_valid_reg;
        cmd_io_next    = cmd_io_reg;
        cmd_opa_next   = cmd_opa_reg;
        cmd_data_next  = cmd_data_reg;
        rsp_data_next  = rsp_data_reg;

        // Command and bus_reset only change on the cycle boundary, so a command
        // always occupies exactly one whole instruction cycle.
        if (cycle_end) begin
            if (bus_reset_reg) begin
                if (rst_cnt_reg == RST_LAST) begin
                    bus_reset_next = 1'b0;
                end else begin
                    rst_cnt_next = rst_cnt_reg + 1'b1;
                end
            end
            cmd_valid_next = accept;
            if (accept) begin
                cmd_io_next   = req_io;
                cmd_opa_next  = req_opa;
                cmd_data_next = req_data;
            end
        end

        if (cmd_read && (cnt_reg == SAMPLE_CNT)) begin
            rsp_data_next = data;
        end
    end

    always_comb begin
        bus_oe   = 1'b0;
        data_out = 4'h0;
        cm       = 1'b0;
        case (sub)
            SUB_A1, SUB_A2, SUB_A3: begin
                bus_oe = 1'b1;
            end
            SUB_M1: begin
                bus_oe   = 1'b1;
                data_out = !cmd_valid_reg ? OPR_NOP : (cmd_io_reg ? OPR_IO : OPR_SRC);
            end
            SUB_M2: begin
                bus_oe   = 1'b1;
                data_out = !cmd_valid_reg ? OPR_NOP : (cmd_io_reg ? cmd_opa_reg : OPA_SRC);
                cm       = cmd_valid_reg && cmd_io_reg;
            end
            SUB_X2: begin
                if (cmd_valid_reg && !cmd_io_reg) begin
                    bus_oe   = 1'b1;
                    data_out = cmd_data_reg[7:4];
                    cm       = 1'b1;
                end else if (cmd_valid_reg && !cmd_opa_reg[3]) begin
                    bus_oe   = 1'b1;
                    data_out = cmd_data_reg[3:0];
                end
            end
            SUB_X3: begin
                if (cmd_valid_reg && !cmd_io_reg) begin
                    bus_oe   = 1'b1;
                    data_out = cmd_data_reg[3:0];
                end
            end
            default: begin
                bus_oe = 1'b0;
            end
        endcase
    end

    // reset_n gates the drivers directly so the bus floats the instant reset asserts.
    assign data_drive = bus_oe && reset_n;

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_data
            assign data[gi] = data_drive ? data_out[gi] : 1'bz;
        end
    endgenerate

endmodule

// File: tb/tb_i4004_bus_master.sv
// Bench for i4004_bus_master: directed command vectors with hand-computed bus
// expectations, a cycle scoreboard for bus contents and a response scoreboard.
`timescale 1ns/1ps
module tb_i4004_bus_master;

    typedef struct {
        int         tag;
        logic       io;
        logic [3:0] opa;
        logic [7:0] dat;
        logic [3:0] e_opr;
        logic [3:0] e_opa;
        logic       x2_drv;
        logic [3:0] x2;
        logic       cm_m2;
        logic       cm_x2;
        logic       x3_drv;
        logic [3:0] x3;
        logic       rd;
        logic [3:0] rd_val;
    } vec_t;

    logic       sysclk;
    logic       reset_n;
    logic       clk1, clk2, sync, bus_reset, cm;
    tri   [3:0] data;
    logic       req_valid, req_ready, req_io;
    logic [3:0] req_opa;
    logic [7:0] req_data;
    logic       rsp_valid;
    logic [3:0] rsp_data;
    logic       tb_oe;
    logic [3:0] tb_val;

    int n_cmp = 0;
    int n_mis = 0;
    int mcnt;
    int cyc;

    vec_t       cyc_q[$];
    logic [3:0] rsp_q[$];
    vec_t       cur;

    assign data = tb_oe ? tb_val : 4'bz;

    i4004_bus_master #(.RESET_CYCLES(32)) dut (
        .sysclk   (sysclk),
        .reset_n  (reset_n),
        .clk1     (clk1),
        .clk2     (clk2),
        .sync     (sync),
        .bus_reset(bus_reset),
        .cm       (cm),
        .data     (data),
        .req_valid(req_valid),
        .req_ready(req_ready),
        .req_io   (req_io),
        .req_opa  (req_opa),
        .req_data (req_data),
        .rsp_valid(rsp_valid),
        .rsp_data (rsp_data)
    );

    initial begin
        sysclk = 1'b0;
        forever #25 sysclk = ~sysclk;
    end

    // Bench's own view of the cycle position.
    always @(posedge sysclk or negedge reset_n) begin
        if (!reset_n) begin
            mcnt <= 0;
            cyc  <= 0;
        end else if (mcnt == 63) begin
            mcnt <= 0;
            cyc  <= cyc + 1;
        end else begin
            mcnt <= mcnt + 1;
        end
    end

    function automatic vec_t mk(logic io, logic [3:0] opa, logic [7:0] dat,
                                logic [3:0] e_opr, logic [3:0] e_opa,
                                logic x2_drv, logic [3:0] x2, logic cm_m2, logic cm_x2,
                                logic x3_drv, logic [3:0] x3, logic rd, logic [3:0] rd_val);
        vec_t v;
        v.tag = 0; v.io = io; v.opa = opa; v.dat = dat;
        v.e_opr = e_opr; v.e_opa = e_opa; v.x2_drv = x2_drv; v.x2 = x2;
        v.cm_m2 = cm_m2; v.cm_x2 = cm_x2; v.x3_drv = x3_drv; v.x3 = x3;
        v.rd = rd; v.rd_val = rd_val;
        return v;
    endfunction

    function automatic void chk(string name, int act, int exp);
        n_cmp++;
        if (act != exp) begin
            n_mis++;
            $display("FAIL %s: got %0h, want %0h (t=%0t cnt=%0d cyc=%0d)", name, act, exp, $time, mcnt, cyc);
        end
    endfunction

    function automatic void fail(string name);
        n_cmp++;
        n_mis++;
        $display("FAIL %s (t=%0t cnt=%0d cyc=%0d)", name, $time, mcnt, cyc);
    endfunction

    vec_t nop_c, v_src5a, v_wrm7, v_rdm7, v_src40, v_wmpc, v_rdb, v_wr35, v_src96, v_rd8;

    initial begin
        nop_c   = mk(1'b0, 4'h0, 8'h00, 4'h0, 4'h0, 1'b0, 4'h0, 1'b0, 1'b0, 1'b0, 4'h0, 1'b0, 4'h0);
        v_src5a = mk(1'b0, 4'h0, 8'h5A, 4'h2, 4'h1, 1'b1, 4'h5, 1'b0, 1'b1, 1'b1, 4'hA, 1'b0, 4'h0);
        v_wrm7  = mk(1'b1, 4'h0, 8'h07, 4'hE, 4'h0, 1'b1, 4'h7, 1'b1, 1'b0, 1'b0, 4'h0, 1'b0, 4'h0);
        v_rdm7  = mk(1'b1, 4'h9, 8'h00, 4'hE, 4'h9, 1'b0, 4'h0, 1'b1, 1'b0, 1'b0, 4'h0, 1'b1, 4'h7);
        v_src40 = mk(1'b0, 4'h0, 8'h40, 4'h2, 4'h1, 1'b1, 4'h4, 1'b0, 1'b1, 1'b1, 4'h0, 1'b0, 4'h0);
        v_wmpc  = mk(1'b1, 4'h1, 8'h0C, 4'hE, 4'h1, 1'b1, 4'hC, 1'b1, 1'b0, 1'b0, 4'h0, 1'b0, 4'h0);
        v_rdb   = mk(1'b1, 4'hB, 8'hF0, 4'hE, 4'hB, 1'b0, 4'h0, 1'b1, 1'b0, 1'b0, 4'h0, 1'b1, 4'hD);
        v_wr35  = mk(1'b1, 4'h4, 8'h35, 4'hE, 4'h4, 1'b1, 4'h5, 1'b1, 1'b0, 1'b0, 4'h0, 1'b0, 4'h0);
        v_src96 = mk(1'b0, 4'h7, 8'h96, 4'h2, 4'h1, 1'b1, 4'h9, 1'b0, 1'b1, 1'b1, 4'h6, 1'b0, 4'h0);
        v_rd8   = mk(1'b1, 4'h8, 8'h5A, 4'hE, 4'h8, 1'b0, 4'h0, 1'b1, 1'b0, 1'b0, 4'h0, 1'b1, 4'h3);
    end

    // Monitor: checks bus timing every half cycle, bus content mid-subcycle,
    // plays the attached device for read cycles and pops the response scoreboard.
    initial begin
        tb_oe  = 1'b0;
        tb_val = 4'h0;
        #1;
        cur = nop_c;
        forever begin
            @(negedge sysclk);
            if (!reset_n) begin
                cur   = nop_c;
                tb_oe = 1'b0;
                chk("rst_clk1", int'(clk1), 0);
                chk("rst_clk2", int'(clk2), 0);
                chk("rst_sync", int'(sync), 0);
                chk("rst_cm", int'(cm), 0);
                chk("rst_bus_reset", int'(bus_reset), 1);
                chk("rst_req_ready", int'(req_ready), 0);
                chk("rst_rsp_valid", int'(rsp_valid), 0);
                chk("rst_rsp_data", int'(rsp_data), 0);
            end else begin
                if (mcnt == 0) begin
                    cur = nop_c;
                    while (cyc_q.size() > 0 && cyc_q[0].tag < cyc) begin
                        fail("cmd_not_executed");
                        void'(cyc_q.pop_front());
                    end
                    if (cyc_q.size() > 0 && cyc_q[0].tag == cyc) cur = cyc_q.pop_front();
                end
                if (mcnt == 48 && cur.rd) begin
                    tb_oe  = 1'b1;
                    tb_val = cur.rd_val;
                end
                if (mcnt == 56) tb_oe = 1'b0;

                chk("clk1", int'(clk1), int'(mcnt % 8 == 1 || mcnt % 8 == 2));
                chk("clk2", int'(clk2), int'(mcnt % 8 == 5 || mcnt % 8 == 6));
                chk("sync", int'(sync), int'(mcnt >= 56));
                chk("bus_reset", int'(bus_reset), int'(cyc < 32));
                chk("req_ready", int'(req_ready), int'(mcnt == 63 && cyc >= 32));
                chk("rsp_valid", int'(rsp_valid), int'(mcnt == 55 && cur.rd));

                if (mcnt % 8 == 4) begin
                    case (mcnt / 8)
                        0, 1, 2: begin
                            chk("data_A", int'(data), 0);
                            chk("cm_A", int'(cm), 0);
                        end
                        3: begin
                            chk("data_M1", int'(data), int'(cur.e_opr));
                            chk("cm_M1", int'(cm), 0);
                        end
                        4: begin
                            chk("data_M2", int'(data), int'(cur.e_opa));
                            chk("cm_M2", int'(cm), int'(cur.cm_m2));
                        end
                        5: chk("cm_X1", int'(cm), 0);
                        6: begin
                            if (cur.x2_drv) chk("data_X2", int'(data), int'(cur.x2));
                            chk("cm_X2", int'(cm), int'(cur.cm_x2));
                        end
                        default: begin
                            if (cur.x3_drv) chk("data_X3", int'(data), int'(cur.x3));
                            chk("cm_X3", int'(cm), 0);
                        end
                    endcase
                end

                if (rsp_valid) begin
                    if (rsp_q.size() == 0) begin
                        fail("unexpected_rsp");
                    end else begin
                        logic [3:0] e;
                        e = rsp_q.pop_front();
                        $display("rsp data=%h expected=%h cyc=%0d", rsp_data, e, cyc);
                        chk("rsp_data", int'(rsp_data), int'(e));
                    end
                end
            end
        end
    end

    task automatic issue(input vec_t v, input bit abort, output int tag);
        int n;
        req_valid = 1'b1;
        req_io    = v.io;
        req_opa   = v.opa;
        req_data  = v.dat;
        n = 0;
        @(negedge sysclk);
        while (!req_ready && n < 2600) begin
            @(negedge sysclk);
            n++;
        end
        if (!req_ready) begin
            fail("ready_timeout");
            req_valid = 1'b0;
            tag = -1;
            return;
        end
        v.tag = cyc + 1;
        tag   = v.tag;
        cyc_q.push_back(v);
        if (v.rd && !abort) rsp_q.push_back(v.rd_val);
        $display("issue io=%0d opa=%h data=%h cycle=%0d", v.io, v.opa, v.dat, v.tag);
        @(posedge sysclk);
        #1;
        req_valid = 1'b0;
    endtask

    initial begin
        #(50 * 90000);
        $display("FAIL watchdog expired (t=%0t)", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        int t;
        int n;
        reset_n   = 1'b0;
        req_valid = 1'b0;
        req_io    = 1'b0;
        req_opa   = 4'h0;
        req_data  = 8'h00;
        repeat (4) @(negedge sysclk);
        #5 reset_n = 1'b1;

        // SRC, WRM, RDM back to back
        issue(v_src5a, 1'b0, t);
        issue(v_wrm7, 1'b0, t);
        issue(v_rdm7, 1'b0, t);
        repeat (130) @(negedge sysclk);

        // SRC then WMP
        issue(v_src40, 1'b0, t);
        issue(v_wmpc, 1'b0, t);
        repeat (70) @(negedge sysclk);

        // four queued commands with req_valid held
        issue(v_rdb, 1'b0, t);
        issue(v_wr35, 1'b0, t);
        issue(v_src96, 1'b0, t);
        issue(v_rd8, 1'b0, t);
        repeat (200) @(negedge sysclk);

        // RDM aborted by reset at cnt=50
        issue(v_rdm7, 1'b1, t);
        n = 0;
        @(negedge sysclk);
        while (!(cyc == t && mcnt == 50) && n < 200) begin
            @(negedge sysclk);
            n++;
        end
        if (!(cyc == t && mcnt == 50)) fail("abort_point_timeout");
        #5 reset_n = 1'b0;
        repeat (3) @(negedge sysclk);
        #5 reset_n = 1'b1;

        // first command after the reinstated bus_reset period
        issue(v_src5a, 1'b0, t);
        repeat (130) @(negedge sysclk);

        chk("rsp_queue_drained", rsp_q.size(), 0);
        chk("cmd_queue_drained", cyc_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
